// File: rtl/button_event_if.sv
// Button event interface: debounced level in, classified event pulses and status out.
// master drives the button level; slave is the classifier.
interface button_event_if;
  logic       db_i;
  logic       press_o;
  logic       release_o;
  logic       long_o;
  logic       rpt_o;
  logic       held_o;
  logic [7:0] press_cnt_o;

  modport master (
    output db_i,
    input  press_o, release_o, long_o, rpt_o, held_o, press_cnt_o
  );

  modport slave (
    input  db_i,
    output press_o, release_o, long_o, rpt_o, held_o, press_cnt_o
  );
endinterface

// File: rtl/button_event.sv
// Press classifier: turns a debounced button level into press/release/long/repeat
// pulses, a held level and a wrapping press counter. Auto-repeat is enabled by BTN_REPEAT_EN.
module button_event #(
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned LONG_TICKS   = 5_000_000,
  parameter int unsigned REPEAT_TICKS = 1_000_000
) (
  input  logic          ck_i,
  input  logic          reset_i,
  button_event_if.slave bus_io
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StDown = 2'd1;
  localparam logic [1:0] StLong = 2'd2;

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_TICKS - 1);

  // Counter must hold the largest terminal compare value.
  if ((((LONG_TICKS - 1) >> CNT_W) != 0) || (((REPEAT_TICKS - 1) >> CNT_W) != 0)) begin : g_cnt_w_chk
    $error("button_event: CNT_W too narrow for LONG_TICKS/REPEAT_TICKS");
  end

  logic             db_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             held_q, held_d;
  logic [7:0]       press_cnt_q, press_cnt_d;
  logic             rise, fall;

  assign rise = bus_io.db_i & ~db_q;
  assign fall = ~bus_io.db_i & db_q;

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] RptLast = CNT_W'(REPEAT_TICKS - 1);
  logic rpt_q, rpt_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    press_cnt_d = press_cnt_q;
`ifdef BTN_REPEAT_EN
    rpt_d       = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // A fall here belongs to a press held through reset: dropped silently.
        if (rise) begin
          state_d     = StDown;
          press_d     = 1'b1;
          press_cnt_d = press_cnt_q + 8'd1;
          cnt_d       = '0;
        end
      end
      StDown: begin
        if (fall) begin
          state_d   = StIdle;
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == LongLast) begin
          state_d = StLong;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StLong: begin
        if (fall) begin
          state_d   = StIdle;
          release_d = 1'b1;
          cnt_d     = '0;
        end
`ifdef BTN_REPEAT_EN
        else if (cnt_q == RptLast) begin
          rpt_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != StIdle);
  end

  // db_q resets high so a button held through reset is not taken as a press.
  always_ff @(posedge ck_i or posedge reset_i) begin
    if (reset_i) begin
      db_q        <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      held_q      <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      db_q        <= bus_io.db_i;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      held_q      <= held_d;
      press_cnt_q <= press_cnt_d;
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge ck_i or posedge reset_i) begin
    if (reset_i) begin
      rpt_q <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
  assign bus_io.rpt_o = rpt_q;
`else
  assign bus_io.rpt_o = 1'b0;
`endif

  assign bus_io.press_o     = press_q;
  assign bus_io.release_o   = release_q;
  assign bus_io.long_o      = long_q;
  assign bus_io.held_o      = held_q;
  assign bus_io.press_cnt_o = press_cnt_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: hold-time reference model checked every cycle, directed
// scenarios pinned with literal expectations, then randomized level/reset stimulus.
module tb_button_event;
  localparam int unsigned L = 8;
  localparam int unsigned R = 4;
  localparam int unsigned W = 8;

  logic ck = 1'b0;
  logic reset = 1'b1;

  button_event_if bus ();

  button_event #(
    .CNT_W       (W),
    .LONG_TICKS  (L),
    .REPEAT_TICKS(R)
  ) dut (
    .ck_i   (ck),
    .reset_i(reset),
    .bus_io (bus)
  );

  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: an accepted press and how long it has been held.
  bit m_active = 0;
  bit m_prev   = 1;
  int m_hold   = 0;
  int m_cnt    = 0;
  bit e_press, e_rel, e_long, e_rpt;

  // Observed DUT pulse history.
  int cyc = 0;
  int n_press = 0, n_rel = 0, n_long = 0, n_rpt = 0, n_held = 0;
  int t_press = 0, t_rel = 0, t_long = 0, t_rpt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called right after a negedge; drives db, advances one clock, updates model, compares.
  task automatic step(input logic d);
    bus.db_i = d;
    @(posedge ck);
    e_press = 0; e_rel = 0; e_long = 0; e_rpt = 0;
    if (reset) begin
      m_active = 0; m_prev = 1; m_hold = 0; m_cnt = 0;
    end else begin
      if (!m_active) begin
        if (d && !m_prev) begin
          e_press = 1; m_active = 1; m_hold = 0; m_cnt = (m_cnt + 1) % 256;
        end
      end else if (!d) begin
        e_rel = 1; m_active = 0;
      end else begin
        m_hold++;
        if (m_hold == L) e_long = 1;
`ifdef BTN_REPEAT_EN
        else if (m_hold > L && ((m_hold - L) % R) == 0) e_rpt = 1;
`endif
      end
      m_prev = d;
    end
    #1;
    cyc++;
    chk("press",     int'(bus.press_o),     int'(e_press));
    chk("release",   int'(bus.release_o),   int'(e_rel));
    chk("long",      int'(bus.long_o),      int'(e_long));
    chk("rpt",       int'(bus.rpt_o),       int'(e_rpt));
    chk("held",      int'(bus.held_o),      int'(m_active));
    chk("press_cnt", int'(bus.press_cnt_o), m_cnt);
    if (bus.press_o)   begin n_press++; t_press = cyc; end
    if (bus.release_o) begin n_rel++;   t_rel   = cyc; end
    if (bus.long_o)    begin n_long++;  t_long  = cyc; end
    if (bus.rpt_o)     begin n_rpt++;   t_rpt   = cyc; end
    if (bus.held_o)    n_held++;
    @(negedge ck);
  endtask

  task automatic run(input logic d, input int n);
    for (int i = 0; i < n; i++) step(d);
  endtask

  int s_press, s_rel, s_long, s_rpt, s_held;
  task automatic snap();
    s_press = n_press; s_rel = n_rel; s_long = n_long; s_rpt = n_rpt; s_held = n_held;
  endtask

  initial begin
    bus.db_i = 1'b1;
    @(negedge ck);
    run(1'b1, 2);
    chk("reset_press",     int'(bus.press_o),     0);
    chk("reset_held",      int'(bus.held_o),      0);
    chk("reset_press_cnt", int'(bus.press_cnt_o), 0);
    reset = 1'b0;

    // Held through reset: no press until released and pressed again.
    run(1'b1, 3);
    run(1'b0, 2);

    // Short 3-cycle press.
    snap();
    run(1'b1, 3);
    run(1'b0, 3);
    chk("s1_presses",   n_press - s_press, 1);
    chk("s1_releases",  n_rel - s_rel, 1);
    chk("s1_longs",     n_long - s_long, 0);
    chk("s1_rel_delay", t_rel - t_press, 3);
    chk("s1_held_cyc",  n_held - s_held, 3);
    chk("s1_press_cnt", int'(bus.press_cnt_o), 1);

    // 30-cycle hold.
    snap();
    run(1'b1, 30);
    run(1'b0, 3);
    chk("s2_longs",      n_long - s_long, 1);
    chk("s2_long_delay", t_long - t_press, 8);
    chk("s2_rel_delay",  t_rel - t_press, 30);
    chk("s2_held_cyc",   n_held - s_held, 30);
`ifdef BTN_REPEAT_EN
    chk("s2_rpts",          n_rpt - s_rpt, 5);
    chk("s2_last_rpt_delay", t_rpt - t_press, 28);
`else
    chk("s2_rpts",          n_rpt - s_rpt, 0);
`endif

    // Fall coincides with long threshold: release wins.
    snap();
    run(1'b1, 8);
    run(1'b0, 3);
    chk("s3_longs",     n_long - s_long, 0);
    chk("s3_releases",  n_rel - s_rel, 1);
    chk("s3_rel_delay", t_rel - t_press, 8);

    // Press counter wrap.
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    step(1'b0);
    for (int i = 0; i < 256; i++) begin
      step(1'b1);
      step(1'b0);
    end
    chk("s4_wrap_256", int'(bus.press_cnt_o), 0);
    step(1'b1);
    step(1'b0);
    chk("s4_wrap_257", int'(bus.press_cnt_o), 1);

    // Asynchronous reset while in LONG, button kept down.
    run(1'b1, 12);
    chk("s5_in_long_held", int'(bus.held_o), 1);
    #2 reset = 1'b1;
    #1;
    chk("s5_async_held",      int'(bus.held_o),      0);
    chk("s5_async_press_cnt", int'(bus.press_cnt_o), 0);
    chk("s5_async_pulses",
        int'(bus.press_o) + int'(bus.release_o) + int'(bus.long_o) + int'(bus.rpt_o), 0);
    @(negedge ck);
    run(1'b1, 2);
    reset = 1'b0;
    run(1'b1, 3);
    snap();
    run(1'b0, 2);
    chk("s5_no_release", n_rel - s_rel, 0);
    step(1'b1);
    chk("s5_new_press", n_press - s_press, 1);
    chk("s5_press_cnt", int'(bus.press_cnt_o), 1);
    step(1'b0);

    // Randomized segments around the thresholds, with occasional resets.
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      logic lvl;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30))
                                        : int'($urandom_range(1, 12));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        run(lvl, int'($urandom_range(1, 2)));
        reset = 1'b0;
      end
      run(lvl, len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
